// File: rtl/mc_control_unit_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
// master = control unit (drives selects/enables), slave = datapath side.
interface mc_control_unit_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               pcen;
  logic               memwrite;
  logic               irwrite;
  logic               regwrite;
  logic               alusrca;
  logic               iord;
  logic               memtoreg;
  logic               regdst;
  logic [1:0]         alusrcb;
  logic [1:0]         pcsrc;
  logic [2:0]         alucontrol;
  logic               illegal;
  logic [STATE_W-1:0] dbg_state;

  modport master (
    input  op, funct, zero,
    output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol, illegal, dbg_state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
           alusrcb, pcsrc, alucontrol, illegal, dbg_state
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multicycle MIPS control: Moore main FSM plus combinational ALU decoder.
// Only pcen depends combinationally on zero; write enables are squashed while reset is high.
module mc_control_unit #(
  parameter int STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  mc_control_unit_if.master   bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IMMEX  = 4'd9,
    S_IMMWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_illegal;
  logic        w_op_bad;

  logic        w_pcwrite;
  logic        w_branch;
  logic        w_bne;
  logic        w_irwrite;
  logic        w_regwrite;
  logic        w_memwrite;
  logic        w_alusrca;
  logic        w_iord;
  logic        w_memtoreg;
  logic        w_regdst;
  logic [1:0]  w_alusrcb;
  logic [1:0]  w_pcsrc;
  logic [1:0]  w_aluop;
  logic [2:0]  w_alucontrol;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      // Registered so the pulse lands in the FETCH cycle that follows DECODE.
      r_illegal <= (r_state == S_DECODE) && w_op_bad;
    end
  end

  always_comb begin
    w_op_bad = 1'b0;
    case (bus.op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_J: w_op_bad = 1'b0;
      default:                                                   w_op_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_bne      = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_alusrca  = 1'b0;
    w_iord     = 1'b0;
    w_memtoreg = 1'b0;
    w_regdst   = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluop    = 2'b00;

    case (r_state)
      S_FETCH: begin
        w_alusrcb = 2'b01;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        w_alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW:     w_next = S_MEMADR;
          OP_R:             w_next = S_EXEC;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_ADDI, OP_SLTI: w_next = S_IMMEX;
          OP_J:             w_next = S_JUMP;
          default:          w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        if (bus.op == OP_LW)      w_next = S_MEMRD;
        else if (bus.op == OP_SW) w_next = S_MEMWR;
        else                      w_next = S_FETCH;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b01;
        w_pcsrc   = 2'b01;
        w_branch  = (bus.op == OP_BEQ);
        w_bne     = (bus.op == OP_BNE);
      end
      S_IMMEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluop   = (bus.op == OP_SLTI) ? 2'b11 : 2'b00;
        w_next    = S_IMMWB;
      end
      S_IMMWB: begin
        w_regwrite = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_alucontrol = 3'b010;
    case (w_aluop)
      2'b00: w_alucontrol = 3'b010;
      2'b01: w_alucontrol = 3'b110;
      2'b11: w_alucontrol = 3'b111;
      default: begin
        case (bus.funct)
          6'b100000: w_alucontrol = 3'b010;
          6'b100010: w_alucontrol = 3'b110;
          6'b100100: w_alucontrol = 3'b000;
          6'b100101: w_alucontrol = 3'b001;
          6'b101010: w_alucontrol = 3'b111;
          default:   w_alucontrol = 3'b010;
        endcase
      end
    endcase
  end

  assign bus.pcen       = ~reset & (w_pcwrite | (w_branch & bus.zero) | (w_bne & ~bus.zero));
  assign bus.irwrite    = ~reset & w_irwrite;
  assign bus.regwrite   = ~reset & w_regwrite;
  assign bus.memwrite   = ~reset & w_memwrite;
  assign bus.alusrca    = w_alusrca;
  assign bus.iord       = w_iord;
  assign bus.memtoreg   = w_memtoreg;
  assign bus.regdst     = w_regdst;
  assign bus.alusrcb    = w_alusrcb;
  assign bus.pcsrc      = w_pcsrc;
  assign bus.alucontrol = w_alucontrol;
  assign bus.illegal    = r_illegal;
  assign bus.dbg_state  = STATE_W'(r_state);

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Control unit for the 32-bit multicycle MIPS core. Sequences the shared-ALU, single-memory datapath through fetch, decode, execute, memory and writeback steps. Contains a Moore main FSM plus a combinational ALU decoder. Drives every datapath select and enable, and consumes op, funct and zero from the datapath.

Parameters:
- STATE_W, 4, width of the state register and of the dbg_state output.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU result == 0
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register enable
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = A
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  write-data select: 0 = ALUOut, 1 = Data
- regdst  out  1  write-register select: 0 = rt, 1 = rd
- alusrcb  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- illegal  out  1  one-cycle pulse on an unsupported opcode
- dbg_state  out  STATE_W  current state encoding

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: on a clk edge with reset=1, state <= FETCH (0) and illegal <= 0.
- While reset=1, pcen, irwrite, regwrite and memwrite are forced to 0 combinationally.
- Reset mid-instruction aborts the instruction: the next cycle after reset deasserts is FETCH.
- Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, SLTI=001010, J=000010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11. Codes 12-15 are unreachable; if entered, go to FETCH.
- Default for every control output is 0; each state asserts only what is listed.
- FETCH: alusrcb=01, irwrite=1, pcwrite=1. Next state DECODE.
- DECODE: alusrcb=11 (branch target captured in ALUOut). Next state by op:
  - LW/SW -> MEMADR
  - R -> EXEC
  - BEQ/BNE -> BRANCH
  - ADDI/SLTI -> IMMEX
  - J -> JUMP
  - anything else -> FETCH, with illegal=1 registered so it pulses during that FETCH cycle.
- MEMADR: alusrca=1, alusrcb=10. Next state MEMRD if LW, MEMWR if SW.
- MEMRD: iord=1. Next state MEMWB.
- MEMWB: memtoreg=1, regwrite=1. Next state FETCH.
- MEMWR: iord=1, memwrite=1. Next state FETCH.
- EXEC: alusrca=1, aluop=10. Next state ALUWB.
- ALUWB: regdst=1, regwrite=1. Next state FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01; branch=1 if BEQ, bne=1 if BNE. Next state FETCH.
- IMMEX: alusrca=1, alusrcb=10; aluop=11 if SLTI, else 00. Next state IMMWB.
- IMMWB: regwrite=1, regdst=0, memtoreg=0. Next state FETCH.
- JUMP: pcsrc=10, pcwrite=1. Next state FETCH.
- pcen = pcwrite | (branch & zero) | (bne & ~zero). This is combinational on zero; all other outputs are pure functions of state.
- ALU decoder (combinational):
  - aluop 00 -> 010; aluop 01 -> 110; aluop 11 -> 111.
  - aluop 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other -> 010.
- Cycle counts, FETCH to next FETCH: LW 5, SW 4, R 4, ADDI/SLTI 4, BEQ/BNE 3, J 3, illegal 2.
- At most one of regwrite and memwrite is high in any cycle. irwrite is high only in FETCH.

Test Plan:
- Reset: hold reset=1 for 3 edges with op=100011 -> dbg_state=0 and pcen, irwrite, regwrite, memwrite all 0 throughout. After release, the first cycle shows FETCH with irwrite=1, pcen=1, alusrcb=01.
- LW (op=100011) -> dbg_state sequence 0,1,2,3,4,0. State 3: iord=1. State 4: memtoreg=1, regwrite=1, regdst=0. Exactly one regwrite pulse and no memwrite.
- R-type (op=0): funct=100010 -> in EXEC alucontrol=110; funct=101010 -> 111. In ALUWB: regdst=1, regwrite=1. Sequence 0,1,6,7,0.
- BEQ (op=000100) in BRANCH: zero=1 -> pcen=1, pcsrc=01; zero=0 -> pcen=0. BNE (op=000101): zero=0 -> pcen=1; zero=1 -> pcen=0. alucontrol=110 in both.
- SLTI (op=001010) -> IMMEX alucontrol=111, alusrcb=10, then IMMWB regwrite=1. J (op=000010) -> JUMP pcsrc=10, pcen=1, sequence 0,1,11,0.
- Illegal op=111111 -> DECODE then FETCH, illegal=1 for exactly one cycle. Reset asserted in MEMWR -> memwrite=0 that cycle, dbg_state=0 next.
